hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and register-file write stalls, branch flush,
// a stall watchdog with a sticky error flag, and saturating stall/flush statistics.
module hazard_ctrl #(
  parameter int unsigned MAX_STALL = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  id_opcode,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        wb_reg_write,
  input  logic        mem_branch,
  input  logic        mem_zero,
  output logic        pc_write,
  output logic        pc_src,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        ex_mem_flush,
  output logic [1:0]  state,
  output logic        stall_err,
  output logic [15:0] stall_cycles,
  output logic [7:0]  flush_events
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_e;

  localparam logic [3:0] WD_LAST = 4'(MAX_STALL - 1);

  state_e      state_q, state_d;
  logic [3:0]  wd_q, wd_d;
  logic        err_q, err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;
  logic        flush_inc;

  logic uses_rs, uses_rt, lu_haz, rf_haz, br_taken, haz;

  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (id_opcode)
      6'b000000, 6'b101011, 6'b000100: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      6'b100011: uses_rs = 1'b1;
      default: ;
    endcase
  end

  assign lu_haz   = ex_mem_read && (ex_rt != 5'd0) &&
                    ((uses_rs && (id_rs == ex_rt)) || (uses_rt && (id_rt == ex_rt)));
  // The register file does not forward a same-cycle write to its read ports.
  assign rf_haz   = wb_reg_write && (uses_rs || uses_rt);
  assign br_taken = mem_branch && mem_zero;
  assign haz      = lu_haz || rf_haz;

  always_comb begin
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    if_id_write  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    state_d      = state_q;
    wd_d         = wd_q;
    err_d        = err_q;
    flush_inc    = 1'b0;
    if (rst) begin
      id_ex_bubble = 1'b1;
      state_d      = RUN;
      wd_d         = 4'd0;
      err_d        = 1'b0;
    end else begin
      case (state_q)
        FLUSH: begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = RUN;
          wd_d         = 4'd0;
        end
        default: begin
          if (br_taken) begin
            pc_write     = 1'b1;
            pc_src       = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = FLUSH;
            wd_d         = 4'd0;
            flush_inc    = 1'b1;
          end else if (haz && (wd_q < WD_LAST)) begin
            id_ex_bubble = 1'b1;
            state_d      = STALL;
            wd_d         = wd_q + 4'd1;
          end else begin
            // Watchdog expiry releases the pipeline exactly like a hazard-free cycle.
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            state_d     = RUN;
            wd_d        = 4'd0;
            if (haz) err_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush_inc && (flush_cnt_q != 8'hFF))    flush_cnt_d = flush_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wd_q        <= 4'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state        = state_q;
  assign stall_err    = err_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;

endmodule
